// File: rtl/imem_loader.sv
// imem_loader: frames a valid/ready byte stream into auto-incrementing instruction-memory writes
module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] MAGIC = 8'hA5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] inst_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0] cnt, idle;
  logic [DATA_W-1:0] acc;
  logic xfer, timed_out;
  assign in_ready = 1'b1;
  assign busy = state != IDLE;
  assign xfer = in_valid && in_ready;
  assign timed_out = busy && !xfer && idle == 8'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inst_we <= 1'b0;
      inst_address <= '0;
      inst_data <= '0;
      cpu_rst_n <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      idle <= '0;
      acc <= '0;
    end else begin
      inst_we <= 1'b0;
      idle <= (!busy || xfer) ? 8'd0 : idle + 8'd1;
      if (timed_out) begin
        state <= IDLE;
        err <= 1'b1;
        cpu_rst_n <= 1'b1;
        idle <= '0;
      end else if (xfer) begin
        case (state)
          IDLE: if (in_data == MAGIC) begin
            state <= ADDR;
            done <= 1'b0;
            err <= 1'b0;
            cpu_rst_n <= 1'b0;
            acc <= '0;
          end
          ADDR: begin
            state <= in_data[7] ? IDLE : LEN;
            err <= in_data[7];
            cpu_rst_n <= in_data[7];
            ptr <= in_data[ADDR_W-1:0];
          end
          LEN: begin
            state <= (in_data == '0) ? IDLE : DATA;
            err <= in_data == '0;
            cpu_rst_n <= in_data == '0;
            cnt <= in_data;
          end
          DATA: begin
            inst_we <= 1'b1;
            inst_address <= ptr;
            inst_data <= in_data;
            ptr <= ptr + 1'b1;
            cnt <= cnt - 8'd1;
            acc <= acc ^ in_data;
            state <= (cnt == 8'd1) ? CSUM : DATA;
          end
          CSUM: begin
            done <= in_data == acc;
            err <= in_data != acc;
            cpu_rst_n <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame tests for imem_loader with a write-logging monitor
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, inst_we, cpu_rst_n, busy, done, err;
  logic [6:0] inst_address;
  logic [7:0] inst_data;
  int n_cmp = 0, n_fail = 0, nw = 0, cyc = 0, rstn_bad = 0;
  logic [6:0] wa[16];
  logic [7:0] wd[16];
  int wc[16];

  imem_loader dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .inst_we(inst_we), .inst_address(inst_address), .inst_data(inst_data), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (inst_we && nw < 16) begin
      wa[nw] = inst_address;
      wd[nw] = inst_data;
      wc[nw] = cyc;
      nw++;
    end
    if (busy && cpu_rst_n) rstn_bad++;
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_data = b;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    idle_cycles(2);
    rst = 0;
    n_cmp++; if ({inst_we, inst_address, inst_data} !== 16'h0) begin n_fail++; $display("FAIL reset_wr got we=%b a=%h d=%h want 0", inst_we, inst_address, inst_data); end
    n_cmp++; if ({cpu_rst_n, busy, done, err, in_ready} !== 5'b10001) begin n_fail++; $display("FAIL reset_status got rstn/busy/done/err/rdy=%b want 10001", {cpu_rst_n, busy, done, err, in_ready}); end
  endtask

  task automatic test_back_to_back;
    nw = 0; rstn_bad = 0;
    send(8'hA5);
    n_cmp++; if ({cpu_rst_n, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_magic rstn/busy got %b want 01", {cpu_rst_n, busy}); end
    send_seq('{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00});
    idle_cycles(2);
    n_cmp++; if (nw !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", nw); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !== {7'h10, 8'h11, 7'h11, 8'h22, 7'h12, 8'h33}) begin n_fail++; $display("FAIL b2b_writes got %h:%h %h:%h %h:%h", wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]); end
    n_cmp++; if (wc[1] !== wc[0] + 1 || wc[2] !== wc[0] + 2) begin n_fail++; $display("FAIL b2b_consec cycles got %0d %0d %0d want consecutive", wc[0], wc[1], wc[2]); end
    n_cmp++; if ({done, err, cpu_rst_n, busy} !== 4'b1010) begin n_fail++; $display("FAIL b2b_status done/err/rstn/busy got %b want 1010", {done, err, cpu_rst_n, busy}); end
    n_cmp++; if (rstn_bad !== 0) begin n_fail++; $display("FAIL b2b_rstn high-while-busy cycles got %0d want 0", rstn_bad); end
  endtask

  task automatic test_wrap;
    nw = 0;
    send_seq('{8'hA5, 8'h7E, 8'h03, 8'h01, 8'h02, 8'h04, 8'h07});
    idle_cycles(2);
    n_cmp++; if (nw !== 3 || {wa[0], wa[1], wa[2]} !== {7'h7E, 7'h7F, 7'h00}) begin n_fail++; $display("FAIL wrap_addr got n=%0d %h %h %h want 7e 7f 00", nw, wa[0], wa[1], wa[2]); end
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL wrap_status done/err got %b want 10", {done, err}); end
  endtask

  task automatic test_bad_csum;
    nw = 0;
    send_seq('{8'hA5, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h00});
    idle_cycles(2);
    n_cmp++; if (nw !== 2) begin n_fail++; $display("FAIL csum_count got %0d want 2", nw); end
    n_cmp++; if ({done, err} !== 2'b01) begin n_fail++; $display("FAIL csum_status done/err got %b want 01", {done, err}); end
    nw = 0;
    send_seq('{8'hA5, 8'h20, 8'h01, 8'h5A, 8'h5A});
    idle_cycles(2);
    n_cmp++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL csum_recover done/err got %b want 10", {done, err}); end
    n_cmp++; if (nw !== 1 || {wa[0], wd[0]} !== {7'h20, 8'h5A}) begin n_fail++; $display("FAIL csum_recover_wr got n=%0d %h:%h want 20:5a", nw, wa[0], wd[0]); end
  endtask

  task automatic test_bad_header;
    int busy_seen;
    nw = 0; busy_seen = 0;
    send(8'h00); busy_seen += busy;
    send(8'hFF); busy_seen += busy;
    send(8'h3C); busy_seen += busy;
    idle_cycles(1);
    n_cmp++; if (busy_seen !== 0 || nw !== 0) begin n_fail++; $display("FAIL garbage busy=%0d writes=%0d want 0 0", busy_seen, nw); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL garbage_done got %b want 1", done); end
    send(8'hA5);
    n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL magic_clear done/err got %b want 00", {done, err}); end
    send(8'h80);
    idle_cycles(1);
    n_cmp++; if ({err, busy, cpu_rst_n} !== 3'b101 || nw !== 0) begin n_fail++; $display("FAIL start_bit7 err/busy/rstn got %b writes=%0d want 101 0", {err, busy, cpu_rst_n}, nw); end
    send_seq('{8'hA5, 8'h00, 8'h00});
    idle_cycles(1);
    n_cmp++; if ({err, busy} !== 2'b10 || nw !== 0) begin n_fail++; $display("FAIL len_zero err/busy got %b writes=%0d want 10 0", {err, busy}, nw); end
  endtask

  task automatic test_timeout;
    nw = 0;
    send_seq('{8'hA5, 8'h00, 8'h04, 8'h11});
    idle_cycles(254);
    n_cmp++; if ({busy, err} !== 2'b10) begin n_fail++; $display("FAIL to_before busy/err got %b want 10", {busy, err}); end
    send(8'h22);
    idle_cycles(254);
    n_cmp++; if ({busy, err, cpu_rst_n} !== 3'b100) begin n_fail++; $display("FAIL to_rearm busy/err/rstn got %b want 100", {busy, err, cpu_rst_n}); end
    idle_cycles(1);
    n_cmp++; if ({busy, err, cpu_rst_n, done} !== 4'b0110) begin n_fail++; $display("FAIL to_abort busy/err/rstn/done got %b want 0110", {busy, err, cpu_rst_n, done}); end
    n_cmp++; if (nw !== 2) begin n_fail++; $display("FAIL to_writes got %0d want 2", nw); end
  endtask

  task automatic test_rst_mid;
    nw = 0;
    send_seq('{8'hA5, 8'h00, 8'h05, 8'h11});
    in_valid = 1; in_data = 8'h22; rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    n_cmp++; if ({inst_we, inst_address, inst_data} !== 16'h0) begin n_fail++; $display("FAIL rst_mid_wr got we=%b a=%h d=%h want 0", inst_we, inst_address, inst_data); end
    n_cmp++; if ({cpu_rst_n, busy, done, err} !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_status rstn/busy/done/err got %b want 1000", {cpu_rst_n, busy, done, err}); end
    idle_cycles(3);
    n_cmp++; if (nw !== 1) begin n_fail++; $display("FAIL rst_mid_drop writes got %0d want 1", nw); end
    nw = 0;
    send_seq('{8'hA5, 8'h40, 8'h01, 8'h77, 8'h77});
    idle_cycles(2);
    n_cmp++; if (nw !== 1 || {wa[0], wd[0]} !== {7'h40, 8'h77} || {done, err} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_fresh n=%0d %h:%h done/err=%b want 1 40:77 10", nw, wa[0], wd[0], {done, err}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_wrap;
    test_bad_csum;
    test_bad_header;
    test_timeout;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
